// File: rtl/fetch_stage_pkg.sv
// Shared CPU definitions used by the instruction-fetch stage: PC width,
// the NOP word, the default reset PC and the fetch FSM state encoding.
// Optional feature macro (used by the files importing this package):
//   FETCH_MISALIGN_EN - report misaligned redirect targets on misalign_f.
package fetch_stage_pkg;

    localparam int PC_BITS = 32;

    localparam logic [31:0] NOP_WORD = 32'd0;

    localparam logic [PC_BITS-1:0] DEFAULT_RESET_PC = '0;

    localparam logic [PC_BITS-1:0] PC_STEP = PC_BITS'(4);

    // IDLE: nothing outstanding, WAIT: request outstanding,
    // HAVE: instruction buffered, DROP: outstanding request killed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HAVE = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // Clears the byte-offset bits so an address lands on a word boundary.
    function automatic logic [PC_BITS-1:0] word_align(input logic [PC_BITS-1:0] addr);
        return {addr[PC_BITS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// fetch_pc_gen: combinational next-PC select for the fetch stage.
// Picks between holding the PC, stepping by 4 and loading a redirect
// target, and provides the PC+4 adder shared with the pc_plus_4f output.
// Arithmetic wraps modulo 2^PC_BITS.
// Macro FETCH_MISALIGN_EN: when defined the redirect target is passed
// through unchanged; otherwise its byte-offset bits are cleared.
module fetch_pc_gen
    import fetch_stage_pkg::*;
(
    input  logic [PC_BITS-1:0] pc,
    input  logic               advance,
    input  logic               redirect,
    input  logic [PC_BITS-1:0] redirect_pc,
    output logic [PC_BITS-1:0] pc_next,
    output logic [PC_BITS-1:0] pc_plus_4
);

    logic [PC_BITS-1:0] target;

    assign pc_plus_4 = pc + PC_STEP;

`ifdef FETCH_MISALIGN_EN
    assign target = redirect_pc;
`else
    assign target = word_align(redirect_pc);
`endif

    // Redirect beats the sequential step; otherwise hold the current PC.
    always_comb begin
        pc_next = pc;
        if (redirect) begin
            pc_next = target;
        end else if (advance) begin
            pc_next = pc_plus_4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the pipelined MIPS core.
// Owns the PC, issues single-outstanding requests to instruction memory,
// buffers the returned word for decode and emits NOP bubbles while the
// memory is busy. Redirects from decode kill any in-flight request; the
// killed response is swallowed in DROP so it never reaches decode.
// Macro FETCH_MISALIGN_EN: adds output misalign_f; a misaligned redirect
// parks the stage in IDLE until the next aligned redirect or clr.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_BITS-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               stall_f,
    input  logic               redirect,
    input  logic [PC_BITS-1:0] redirect_pc,
    output logic               imem_req,
    output logic [PC_BITS-1:0] imem_addr,
    input  logic               imem_rvalid,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        instr_f,
    output logic [PC_BITS-1:0] pc_f,
    output logic [PC_BITS-1:0] pc_plus_4f,
    output logic               bubble_f
`ifdef FETCH_MISALIGN_EN
    ,
    output logic               misalign_f
`endif
);

`ifdef FETCH_MISALIGN_EN
    localparam logic [PC_BITS-1:0] RESET_PC_EFF = RESET_PC;
`else
    localparam logic [PC_BITS-1:0] RESET_PC_EFF = word_align(RESET_PC);
`endif

    fetch_state_t       state;
    fetch_state_t       next_state;
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] pc_next;
    logic [PC_BITS-1:0] pc_plus_4;
    logic [31:0]        buffer;
    logic               valid;
    logic               advance;
    logic               load_buf;
    logic               parked;

    fetch_pc_gen u_pc_gen (
        .pc          (pc),
        .advance     (advance),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_next     (pc_next),
        .pc_plus_4   (pc_plus_4)
    );

`ifdef FETCH_MISALIGN_EN
    logic misalign;

    // Misalign flag tracks the alignment of the most recent redirect target.
    always_ff @(posedge clk) begin
        if (clr) begin
            misalign <= 1'b0;
        end else if (redirect) begin
            misalign <= |redirect_pc[1:0];
        end
    end

    assign parked     = misalign;
    assign misalign_f = misalign;
`else
    assign parked = 1'b0;
`endif

    // State, PC and instruction buffer registers.
    always_ff @(posedge clk) begin
        if (clr) begin
            state  <= IDLE;
            pc     <= RESET_PC_EFF;
            buffer <= NOP_WORD;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            if (load_buf) begin
                buffer <= imem_rdata;
            end
        end
    end

    // Next-state and memory-request decode; a redirect overrides everything
    // and a response arriving with it is treated as the killed one.
    always_comb begin
        next_state = state;
        imem_req   = 1'b0;
        imem_addr  = pc;
        advance    = 1'b0;
        load_buf   = 1'b0;
        if (redirect) begin
            if ((state == WAIT || state == DROP) && !imem_rvalid) begin
                next_state = DROP;
            end else begin
                next_state = IDLE;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (!parked) begin
                        imem_req   = 1'b1;
                        imem_addr  = pc;
                        next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        load_buf   = 1'b1;
                        next_state = HAVE;
                    end
                end
                HAVE: begin
                    if (!stall_f) begin
                        advance    = 1'b1;
                        imem_req   = 1'b1;
                        imem_addr  = pc_plus_4;
                        next_state = WAIT;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
        if (clr) begin
            imem_req = 1'b0;
        end
    end

    // Decode-facing outputs; only HAVE holds a live instruction.
    always_comb begin
        valid      = (state == HAVE);
        instr_f    = valid ? buffer : NOP_WORD;
        bubble_f   = !valid;
        pc_f       = pc;
        pc_plus_4f = pc_plus_4;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage with RESET_PC = 32'h400. The memory side is
// driven directly from the vector table (rvalid/rdata per cycle), so each
// row states one cycle's inputs and the outputs expected in that cycle.
// Macro FETCH_MISALIGN_EN selects the matching misalign sequence.
module tb_fetch_stage;

    typedef struct {
        logic        clr;
        logic        stall;
        logic        redir;
        logic [31:0] rpc;
        logic        rvalid;
        logic [31:0] rdata;
        logic        req;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        bubble;
    } vec_t;

    logic        clk = 1'b0;
    logic        clr;
    logic        stall_f;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instr_f;
    logic [31:0] pc_f;
    logic [31:0] pc_plus_4f;
    logic        bubble_f;
`ifdef FETCH_MISALIGN_EN
    logic        misalign_f;
`endif

    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];

    fetch_stage #(.RESET_PC(32'h0000_0400)) dut (
        .clk         (clk),
        .clr         (clr),
        .stall_f     (stall_f),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_f     (instr_f),
        .pc_f        (pc_f),
        .pc_plus_4f  (pc_plus_4f),
        .bubble_f    (bubble_f)
`ifdef FETCH_MISALIGN_EN
        ,
        .misalign_f  (misalign_f)
`endif
    );

    always #5 clk = ~clk;

    task automatic add(input logic c, input logic s, input logic r, input logic [31:0] rpc,
                       input logic v, input logic [31:0] rd, input logic rq, input logic [31:0] ad,
                       input logic [31:0] ins, input logic [31:0] p, input logic [31:0] p4,
                       input logic b);
        vec_t x;
        x.clr = c; x.stall = s; x.redir = r; x.rpc = rpc; x.rvalid = v; x.rdata = rd;
        x.req = rq; x.addr = ad; x.instr = ins; x.pc = p; x.pc4 = p4; x.bubble = b;
        vecs.push_back(x);
    endtask

    task automatic applyStimulus(input logic c, input logic s, input logic r,
                                 input logic [31:0] rpc, input logic v, input logic [31:0] rd);
        clr = c; stall_f = s; redirect = r; redirect_pc = rpc;
        imem_rvalid = v; imem_rdata = rd;
    endtask

    task automatic checkOutput(input string name, input int row,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s row %0d: got %h, expected %h", name, row, actual, expected);
        end
    endtask

    initial begin
        // clr, stall, redir, rpc, rvalid, rdata | req, addr, instr, pc, pc4, bubble
        add(1,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h400,32'h404,1);
        add(0,0,0,32'h0,0,32'h0,                 1,32'h400,32'h0,32'h400,32'h404,1);
        add(0,0,0,32'h0,1,32'h2001_0005,         0,32'h0,32'h0,32'h400,32'h404,1);
        add(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h2001_0005,32'h400,32'h404,0);
        add(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h2001_0005,32'h400,32'h404,0);
        add(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h2001_0005,32'h400,32'h404,0);
        add(0,0,0,32'h0,0,32'h0,                 1,32'h404,32'h2001_0005,32'h400,32'h404,0);
        add(0,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h404,32'h408,1);
        add(0,0,1,32'h800,0,32'h0,               0,32'h0,32'h0,32'h404,32'h408,1);
        add(0,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h800,32'h804,1);
        add(0,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h800,32'h804,1);
        add(0,0,0,32'h0,1,32'hDEAD_BEEF,         0,32'h0,32'h0,32'h800,32'h804,1);
        add(0,0,0,32'h0,0,32'h0,                 1,32'h800,32'h0,32'h800,32'h804,1);
        add(0,0,0,32'h0,1,32'h8C02_0000,         0,32'h0,32'h0,32'h800,32'h804,1);
        add(0,0,0,32'h0,0,32'h0,                 1,32'h804,32'h8C02_0000,32'h800,32'h804,0);
        add(0,0,0,32'h0,1,32'h0000_0020,         0,32'h0,32'h0,32'h804,32'h808,1);
        add(0,1,1,32'h800,0,32'h0,               0,32'h0,32'h0000_0020,32'h804,32'h808,0);
        add(0,1,0,32'h0,0,32'h0,                 1,32'h800,32'h0,32'h800,32'h804,1);
        add(0,0,1,32'hFFFF_FFFC,1,32'h1234_5678, 0,32'h0,32'h0,32'h800,32'h804,1);
        add(0,0,0,32'h0,0,32'h0,                 1,32'hFFFF_FFFC,32'h0,32'hFFFF_FFFC,32'h0,1);
        add(0,0,0,32'h0,1,32'hAABB_CCDD,         0,32'h0,32'h0,32'hFFFF_FFFC,32'h0,1);
        add(0,0,0,32'h0,0,32'h0,                 1,32'h0,32'hAABB_CCDD,32'hFFFF_FFFC,32'h0,0);
        add(0,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h0,32'h4,1);
        add(0,0,0,32'h0,1,32'h1111_1111,         0,32'h0,32'h0,32'h0,32'h4,1);
        add(0,1,0,32'h0,1,32'h9999_9999,         0,32'h0,32'h1111_1111,32'h0,32'h4,0);
        add(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h1111_1111,32'h0,32'h4,0);
        add(0,0,0,32'h0,0,32'h0,                 1,32'h4,32'h1111_1111,32'h0,32'h4,0);
        add(1,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h4,32'h8,1);
        add(0,0,0,32'h0,1,32'hDEAD_BEEF,         1,32'h400,32'h0,32'h400,32'h404,1);
        add(0,0,0,32'h0,0,32'h0,                 0,32'h0,32'h0,32'h400,32'h404,1);
        add(0,0,0,32'h0,1,32'h0000_ABCD,         0,32'h0,32'h0,32'h400,32'h404,1);
        add(0,1,0,32'h0,0,32'h0,                 0,32'h0,32'h0000_ABCD,32'h400,32'h404,0);

        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].clr, vecs[i].stall, vecs[i].redir, vecs[i].rpc,
                          vecs[i].rvalid, vecs[i].rdata);
            #1;
            checkOutput("imem_req", i, 32'(imem_req), 32'(vecs[i].req));
            if (vecs[i].req) checkOutput("imem_addr", i, imem_addr, vecs[i].addr);
            checkOutput("instr_f", i, instr_f, vecs[i].instr);
            checkOutput("pc_f", i, pc_f, vecs[i].pc);
            checkOutput("pc_plus_4f", i, pc_plus_4f, vecs[i].pc4);
            checkOutput("bubble_f", i, 32'(bubble_f), 32'(vecs[i].bubble));
            @(negedge clk);
        end

        // Stage is in HAVE with pc 32'h400 here.
`ifdef FETCH_MISALIGN_EN
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("misalign_f_idle", 100, 32'(misalign_f), 32'h0);
        applyStimulus(0, 0, 1, 32'h802, 0, 32'h0);
        #1;
        checkOutput("imem_req_misredir", 101, 32'(imem_req), 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("misalign_f_set", 102, 32'(misalign_f), 32'h1);
        checkOutput("pc_f_mis", 102, pc_f, 32'h802);
        checkOutput("imem_req_parked", 102, 32'(imem_req), 32'h0);
        checkOutput("bubble_f_parked", 102, 32'(bubble_f), 32'h1);
        @(negedge clk);
        #1;
        checkOutput("imem_req_parked2", 103, 32'(imem_req), 32'h0);
        checkOutput("instr_f_parked", 103, instr_f, 32'h0);
        applyStimulus(0, 0, 1, 32'h900, 0, 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("misalign_f_clear", 104, 32'(misalign_f), 32'h0);
        checkOutput("imem_req_aligned", 104, 32'(imem_req), 32'h1);
        checkOutput("imem_addr_aligned", 104, imem_addr, 32'h900);
        @(negedge clk);
        applyStimulus(0, 0, 1, 32'h803, 0, 32'h0);
        @(negedge clk);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("misalign_f_before_clr", 105, 32'(misalign_f), 32'h1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("misalign_f_after_clr", 106, 32'(misalign_f), 32'h0);
        checkOutput("imem_req_after_clr", 106, 32'(imem_req), 32'h1);
        checkOutput("imem_addr_after_clr", 106, imem_addr, 32'h400);
`else
        applyStimulus(0, 1, 1, 32'h903, 0, 32'h0);
        #1;
        checkOutput("imem_req_redir", 100, 32'(imem_req), 32'h0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
        #1;
        checkOutput("pc_f_masked", 101, pc_f, 32'h900);
        checkOutput("imem_req_masked", 101, 32'(imem_req), 32'h1);
        checkOutput("imem_addr_masked", 101, imem_addr, 32'h900);
`endif
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
